// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
// The fetch unit is the master: it drives the request and address, and memory answers with ready and data.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS32 fetch stage: PC register, single-outstanding imem requests, 2-entry
// instruction queue for decode, and redirect/squash on branch or jump.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  input  logic                   stall,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic [31:0]            instr_pc,
  output logic                   instr_valid,
  output logic [31:0]            pc
);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic        req, req_n;
  logic [31:0] addr, addr_n;
  logic [1:0]  occ, occ_n, occ_pop;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr_n [2];
  logic [31:0] q_pc_n    [2];

  logic        redirect, pop, complete, push, outstanding_n;
  logic [31:0] target;

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign instr          = q_instr[0];
  assign instr_pc       = q_pc[0];
  assign instr_valid    = (occ != 2'd0);

  always_comb begin
    redirect      = branch_taken | jump;
    target        = (branch_taken ? branch_target : jump_target) & ~32'h3;
    pop           = instr_valid & ~stall;
    complete      = req & imem.imem_ready;
    push          = complete & (state == FETCH) & ~redirect;
    outstanding_n = req & ~imem.imem_ready;

    state_n   = state;
    pc_n      = pc;
    req_n     = req;
    addr_n    = addr;
    q_instr_n = q_instr;
    q_pc_n    = q_pc;

    // Queue: entry 0 is the head; a pop shifts entry 1 forward before any push lands.
    occ_pop = occ - {1'b0, pop};
    if (pop) begin
      q_instr_n[0] = q_instr[1];
      q_pc_n[0]    = q_pc[1];
    end
    if (push) begin
      if (occ_pop == 2'd0) begin
        q_instr_n[0] = imem.imem_rdata;
        q_pc_n[0]    = addr;
      end else begin
        q_instr_n[1] = imem.imem_rdata;
        q_pc_n[1]    = addr;
      end
    end
    occ_n = redirect ? 2'd0 : occ_pop + {1'b0, push};

    if (redirect)  pc_n = target;
    else if (push) pc_n = pc + 32'd4;

    case (state)
      FETCH:   if (redirect && outstanding_n) state_n = DISCARD;
      DISCARD: if (imem.imem_ready)          state_n = FETCH;
      default: state_n = FETCH;
    endcase

    // Issue only when nothing will be in flight and the queue keeps a free slot for the reply.
    if (!outstanding_n) begin
      if (occ_n < 2'd2) begin
        req_n  = 1'b1;
        addr_n = pc_n;
      end else begin
        req_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req        <= 1'b0;
      addr       <= 32'd0;
      occ        <= 2'd0;
      q_instr[0] <= 32'd0;
      q_instr[1] <= 32'd0;
      q_pc[0]    <= 32'd0;
      q_pc[1]    <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req        <= req_n;
      addr       <= addr_n;
      occ        <= occ_n;
      q_instr[0] <= q_instr_n[0];
      q_instr[1] <= q_instr_n[1];
      q_pc[0]    <= q_pc_n[0];
      q_pc[1]    <= q_pc_n[1];
    end
  end

endmodule
